// File: rtl/chrono_time_counter.sv
// Chronometer time accumulator: BCD MM:SS.cc counter with run/pause/clear control,
// lap-hold display freeze and start/stop handshake to the tick generator.
module chrono_time_counter #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       gen_start,
  output logic       gen_stop,
  output logic       running,
  output logic       hold,
  output logic       wrap,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o
);

  localparam int unsigned PW = 8;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0] MIN_LIM_T = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_LIM_O = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
  } bcd_time_t;

  state_e          state_q, state_d;
  bcd_time_t       live_q, live_d;
  bcd_time_t       snap_q, snap_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            hold_q, hold_d;
  logic            wrap_q, wrap_d;
  logic            gen_start_q, gen_start_d;
  logic            gen_stop_q, gen_stop_d;
  logic            running_q, running_d;

  bcd_time_t       live_inc;
  logic            at_max;

  // BCD ripple increment of the live count; wraps to zero past MIN_LIMIT:59.99
  always_comb begin
    live_inc = live_q;
    at_max   = 1'b0;
    if (live_q.cs_o != 4'd9) begin
      live_inc.cs_o = live_q.cs_o + 4'd1;
    end else begin
      live_inc.cs_o = 4'd0;
      if (live_q.cs_t != 4'd9) begin
        live_inc.cs_t = live_q.cs_t + 4'd1;
      end else begin
        live_inc.cs_t = 4'd0;
        if (live_q.sec_o != 4'd9) begin
          live_inc.sec_o = live_q.sec_o + 4'd1;
        end else begin
          live_inc.sec_o = 4'd0;
          if (live_q.sec_t != 4'd5) begin
            live_inc.sec_t = live_q.sec_t + 4'd1;
          end else begin
            live_inc.sec_t = 4'd0;
            if (live_q.min_t == MIN_LIM_T && live_q.min_o == MIN_LIM_O) begin
              live_inc = '0;
              at_max   = 1'b1;
            end else if (live_q.min_o != 4'd9) begin
              live_inc.min_o = live_q.min_o + 4'd1;
            end else begin
              live_inc.min_o = 4'd0;
              live_inc.min_t = live_q.min_t + 4'd1;
            end
          end
        end
      end
    end
  end

  // Control FSM next-state, lap hold and prescaled counting
  always_comb begin
    state_d     = state_q;
    live_d      = live_q;
    snap_d      = snap_q;
    presc_d     = presc_q;
    hold_d      = hold_q;
    wrap_d      = 1'b0;
    gen_start_d = 1'b0;

    if (clear) begin
      state_d = IDLE;
      live_d  = '0;
      snap_d  = '0;
      presc_d = '0;
      hold_d  = 1'b0;
    end else begin
      if (start_stop) begin
        case (state_q)
          RUNNING: state_d = PAUSED;
          default: begin
            state_d     = RUNNING;
            gen_start_d = 1'b1;
          end
        endcase
      end else if (lap && state_q == RUNNING) begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          snap_d = live_q;
          hold_d = 1'b1;
        end
      end

      // Qualification uses the current state, so a resume-cycle tick is dropped
      if (tick && state_q == RUNNING) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          live_d  = live_inc;
          wrap_d  = at_max;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end

    running_d  = (state_d == RUNNING);
    gen_stop_d = (state_d != RUNNING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      live_q      <= '0;
      snap_q      <= '0;
      presc_q     <= '0;
      hold_q      <= 1'b0;
      wrap_q      <= 1'b0;
      gen_start_q <= 1'b0;
      gen_stop_q  <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      snap_q      <= snap_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      wrap_q      <= wrap_d;
      gen_start_q <= gen_start_d;
      gen_stop_q  <= gen_stop_d;
      running_q   <= running_d;
    end
  end

  assign gen_start = gen_start_q;
  assign gen_stop  = gen_stop_q;
  assign running   = running_q;
  assign hold      = hold_q;
  assign wrap      = wrap_q;

  // Display view: frozen snapshot while held, otherwise the live count
  assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = hold_q ? snap_q : live_q;

endmodule
